// File: rtl/adbg_tap_pkg.sv
// Shared definitions for the debug JTAG TAP: state encoding, instruction codes
// and default capture/ID values.
package adbg_tap_pkg;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PA_DR  = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PA_IR  = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_t;

    localparam logic [3:0] JTAG_EXTEST         = 4'b0000;
    localparam logic [3:0] JTAG_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [3:0] JTAG_IDCODE         = 4'b0010;
    localparam logic [3:0] JTAG_DEBUG          = 4'b1000;
    localparam logic [3:0] JTAG_MBIST          = 4'b1001;
    localparam logic [3:0] JTAG_BYPASS         = 4'b1111;

    localparam logic [3:0]  IR_CAPTURE_DEFAULT   = 4'b0101;
    localparam logic [31:0] IDCODE_VALUE_DEFAULT = 32'h149511C3;

endpackage

// File: rtl/adbg_tap_fsm.sv
// IEEE 1149.1 TAP state machine with registered state and combinational
// state decodes.
module adbg_tap_fsm
    import adbg_tap_pkg::*;
(
    input  logic tck,
    input  logic rst,
    input  logic tms,
    output logic tlr,
    output logic capture_dr,
    output logic shift_dr,
    output logic pause_dr,
    output logic update_dr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir,
    output logic enter_tlr
);

    tap_state_t state, state_next;

    always_ff @(posedge tck or posedge rst) begin
        if (rst) state <= TLR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            TLR:    state_next = tms ? TLR    : RTI;
            RTI:    state_next = tms ? SEL_DR : RTI;
            SEL_DR: state_next = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_next = tms ? EX1_DR : SH_DR;
            SH_DR:  state_next = tms ? EX1_DR : SH_DR;
            EX1_DR: state_next = tms ? UPD_DR : PA_DR;
            PA_DR:  state_next = tms ? EX2_DR : PA_DR;
            EX2_DR: state_next = tms ? UPD_DR : SH_DR;
            UPD_DR: state_next = tms ? SEL_DR : RTI;
            SEL_IR: state_next = tms ? TLR    : CAP_IR;
            CAP_IR: state_next = tms ? EX1_IR : SH_IR;
            SH_IR:  state_next = tms ? EX1_IR : SH_IR;
            EX1_IR: state_next = tms ? UPD_IR : PA_IR;
            PA_IR:  state_next = tms ? EX2_IR : PA_IR;
            EX2_IR: state_next = tms ? UPD_IR : SH_IR;
            UPD_IR: state_next = tms ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase
    end

    // Decodes come straight from the state register so they stay clean for the whole cycle
    assign tlr        = (state == TLR);
    assign capture_dr = (state == CAP_DR);
    assign shift_dr   = (state == SH_DR);
    assign pause_dr   = (state == PA_DR);
    assign update_dr  = (state == UPD_DR);
    assign capture_ir = (state == CAP_IR);
    assign shift_ir   = (state == SH_IR);
    assign update_ir  = (state == UPD_IR);
    assign enter_tlr  = (state_next == TLR);

endmodule

// File: rtl/adbg_jtag_tap.sv
// Debug JTAG TAP: instruction register, IDCODE/BYPASS data registers and the
// TDO mux that splices in the debug top-level chain.
module adbg_jtag_tap
    import adbg_tap_pkg::*;
#(
    parameter int unsigned             IR_LENGTH    = 4,
    parameter logic [31:0]             IDCODE_VALUE = IDCODE_VALUE_DEFAULT,
    parameter logic [IR_LENGTH-1:0]    IR_CAPTURE   = IR_CAPTURE_DEFAULT
) (
    input  logic tck_i,
    input  logic rst_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    input  logic debug_tdo_i,
    output logic tlr_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic debug_select_o
);

    logic                 tlr, capture_ir, shift_ir, update_ir, enter_tlr;
    logic [IR_LENGTH-1:0] ir, ir_shift;
    logic [31:0]          idcode_sr;
    logic                 bypass;
    logic                 is_idcode, is_debug;
    logic                 tdo_mux;

    adbg_tap_fsm u_fsm (
        .tck        (tck_i),
        .rst        (rst_i),
        .tms        (tms_i),
        .tlr        (tlr),
        .capture_dr (capture_dr_o),
        .shift_dr   (shift_dr_o),
        .pause_dr   (pause_dr_o),
        .update_dr  (update_dr_o),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .enter_tlr  (enter_tlr)
    );

    assign tlr_o = tlr | rst_i;

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i)           ir_shift <= '0;
        else if (capture_ir) ir_shift <= IR_CAPTURE;
        else if (shift_ir)   ir_shift <= {tdi_i, ir_shift[IR_LENGTH-1:1]};
    end

    // IR is forced to IDCODE on the edge that enters TLR, so it is valid throughout TLR
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i)          ir <= IR_LENGTH'(JTAG_IDCODE);
        else if (enter_tlr) ir <= IR_LENGTH'(JTAG_IDCODE);
        else if (update_ir) ir <= ir_shift;
    end

    assign is_idcode      = (ir == IR_LENGTH'(JTAG_IDCODE));
    assign is_debug       = (ir == IR_LENGTH'(JTAG_DEBUG));
    assign debug_select_o = is_debug;

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            idcode_sr <= '0;
            bypass    <= 1'b0;
        end else if (capture_dr_o) begin
            if (is_idcode) idcode_sr <= IDCODE_VALUE;
            bypass <= 1'b0;
        end else if (shift_dr_o) begin
            idcode_sr <= {tdi_i, idcode_sr[31:1]};
            bypass    <= tdi_i;
        end
    end

    // EXTEST, SAMPLE_PRELOAD, MBIST and unknown codes all fall through to bypass
    always_comb begin
        tdo_mux = 1'b0;
        if (shift_ir) begin
            tdo_mux = ir_shift[0];
        end else if (shift_dr_o) begin
            if (is_idcode)     tdo_mux = idcode_sr[0];
            else if (is_debug) tdo_mux = debug_tdo_i;
            else               tdo_mux = bypass;
        end
    end

    always_ff @(negedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            tdo_o    <= tdo_mux;
            tdo_oe_o <= shift_ir | shift_dr_o;
        end
    end

endmodule
